// File: rtl/urv_dm_responder.sv
// Data-memory responder for the urv_cpu dm_* port: word RAM with programmable
// wait states, plus a console TX data/status register pair backed by a byte FIFO.
module urv_dm_responder #(
    parameter int          MEM_WORDS   = 16384,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] TX_ADDR     = 32'h0010_0000,
    parameter int          TX_DEPTH    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        proto_err_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(TX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_e;

    // Request bookkeeping
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        is_load_q, is_load_d;
    logic        proto_err_q, proto_err_d;
    logic [31:0] reg_rdata_q, reg_rdata_d;
    logic [31:0] data_l_q, data_l_d;

    // TX FIFO bookkeeping
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Storage
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] ram_rdata_q;
    logic [7:0]  tx_mem [TX_DEPTH];

    // Decode and datapath helpers
    logic          any_strobe;
    logic          is_tx, is_stat, is_ram;
    logic [AW-1:0] word_idx;
    logic          fifo_full;
    logic          tx_push_req, push, pop, xfer_stall;
    logic          ram_we, ram_re;
    logic [31:0]   status_word;
    logic [31:0]   load_val;

    assign any_strobe  = dm_load_i | dm_store_i;
    assign is_tx       = (addr_q == TX_ADDR);
    assign is_stat     = (addr_q == TX_ADDR + 32'd4);
    assign is_ram      = !is_tx && !is_stat;
    assign word_idx    = addr_q[AW+1:2];
    assign fifo_full   = (level_q == FULL_LEVEL);
    assign status_word = {fifo_full, 15'b0, 16'(level_q)};

    // A full FIFO holds the TX store in XFER; a pop frees a slot for the next cycle.
    assign tx_push_req = (state_q == S_XFER) && !is_load_q && is_tx && sel_q[0];
    assign push        = tx_push_req && !fifo_full;
    assign xfer_stall  = tx_push_req && fifo_full;
    assign pop         = tx_valid_o && tx_ready_i;

    assign ram_we = (state_q == S_XFER) && !is_load_q && is_ram;
    assign ram_re = (state_q == S_XFER) && is_load_q && is_ram;

    assign dm_load_done_o  = (state_q == S_DONE) && is_load_q;
    assign dm_store_done_o = (state_q == S_DONE) && !is_load_q;

    // Load data is live from the read path during DONE, then held in data_l_q.
    assign load_val    = is_ram ? ram_rdata_q : reg_rdata_q;
    assign dm_data_l_o = dm_load_done_o ? load_val : data_l_q;

    assign tx_valid_o  = (level_q != '0);
    assign tx_data_o   = tx_valid_o ? tx_mem[rd_ptr_q] : 8'h00;
    assign proto_err_o = proto_err_q;

    // Request FSM: capture, wait-state countdown, transfer, completion pulse.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        is_load_d   = is_load_q;
        proto_err_d = proto_err_q;
        reg_rdata_d = reg_rdata_q;
        data_l_d    = data_l_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (any_strobe) begin
                    addr_d    = dm_addr_i;
                    wdata_d   = dm_data_s_i;
                    sel_d     = dm_data_select_i;
                    is_load_d = dm_load_i;
                    cnt_d     = WAIT_INIT;
                    state_d   = (WAIT_STATES > 0) ? S_WAIT : S_XFER;
                    if (dm_load_i && dm_store_i) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (any_strobe) begin
                    proto_err_d = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (any_strobe) begin
                    proto_err_d = 1'b1;
                end
                if (is_load_q) begin
                    reg_rdata_d = is_stat ? status_word : 32'h0;
                end
                if (!xfer_stall) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (dm_load_done_o) begin
            data_l_d = load_val;
        end
    end

    // TX FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            is_load_q   <= 1'b0;
            proto_err_q <= 1'b0;
            reg_rdata_q <= '0;
            data_l_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            is_load_q   <= is_load_d;
            proto_err_q <= proto_err_d;
            reg_rdata_q <= reg_rdata_d;
            data_l_q    <= data_l_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Word RAM with per-lane writes and a registered read port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage arrays carry no reset, so RAM survives rst_i and maps onto block memory.
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem[word_idx];
        end
    end

    // TX FIFO byte storage; the head is gated to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tx_mem[wr_ptr_q] <= wdata_q[7:0];
        end
    end

endmodule

// File: tb/tb_urv_dm_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) driven by directed
// steps and random traffic, compared against a word/queue model of the memory map.
module tb_urv_dm_responder;

    localparam logic [31:0] TX_A   = 32'h0010_0000;
    localparam logic [31:0] STAT_A = 32'h0010_0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr_i [2];
    logic [31:0] wdat_i [2];
    logic [3:0]  sel_i  [2];
    logic        st_i   [2];
    logic        ld_i   [2];
    logic        rdy_i  [2];
    logic [31:0] data_l [2];
    logic        store_done [2];
    logic        load_done  [2];
    logic [7:0]  tx_data  [2];
    logic        tx_valid [2];
    logic        perr     [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram_m [int];
    logic [7:0]  txq [$];

    urv_dm_responder #(.WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .dm_addr_i(addr_i[0]), .dm_data_s_i(wdat_i[0]), .dm_data_select_i(sel_i[0]),
        .dm_store_i(st_i[0]), .dm_load_i(ld_i[0]),
        .dm_data_l_o(data_l[0]), .dm_store_done_o(store_done[0]), .dm_load_done_o(load_done[0]),
        .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]), .tx_ready_i(rdy_i[0]),
        .proto_err_o(perr[0])
    );

    urv_dm_responder #(.WAIT_STATES(3)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .dm_addr_i(addr_i[1]), .dm_data_s_i(wdat_i[1]), .dm_data_select_i(sel_i[1]),
        .dm_store_i(st_i[1]), .dm_load_i(ld_i[1]),
        .dm_data_l_o(data_l[1]), .dm_store_done_o(store_done[1]), .dm_load_done_o(load_done[1]),
        .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]), .tx_ready_i(rdy_i[1]),
        .proto_err_o(perr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int key_of(input int k, input logic [31:0] a);
        return k * 16384 + int'(a[15:2]);
    endfunction

    // Random alias of a word index: random upper bits (clear of the TX window) and byte offset.
    function automatic logic [31:0] mk_addr(input int idx);
        logic [15:0] upper;
        upper = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom_range(32, 255));
        return {upper, 14'(idx), 2'($urandom_range(0, 3))};
    endfunction

    // Issue one strobe at the current time (just after an edge) and count edges to done.
    task automatic do_req(input int k, input bit ld, input bit st, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rdata, output int lat, output bit was_load);
        ld_i[k] = ld; st_i[k] = st; addr_i[k] = a; wdat_i[k] = d; sel_i[k] = s;
        @(posedge clk); #1;
        ld_i[k] = 1'b0; st_i[k] = 1'b0;
        lat = -1; rdata = 32'hx; was_load = 1'b0;
        for (int c = 2; c <= 40; c++) begin
            @(posedge clk); #1;
            if (load_done[k] || store_done[k]) begin
                lat = c; rdata = data_l[k]; was_load = load_done[k];
                break;
            end
        end
    endtask

    task automatic ram_store(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, w;
        int lat;
        bit wl;
        do_req(k, 1'b0, 1'b1, a, d, s, rd, lat, wl);
        check("store_latency", 32'(lat), 32'(2 + wait_of(k)));
        check("store_kind", {31'b0, wl}, 32'd0);
        w = ram_m.exists(key_of(k, a)) ? ram_m[key_of(k, a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ram_m[key_of(k, a)] = w;
    endtask

    task automatic ram_load(input int k, input logic [31:0] a, output logic [31:0] rd);
        int lat;
        bit wl;
        do_req(k, 1'b1, 1'b0, a, 32'h0, 4'h0, rd, lat, wl);
        check("load_latency", 32'(lat), 32'(2 + wait_of(k)));
        check("load_kind", {31'b0, wl}, 32'd1);
        check("load_data", rd, ram_m[key_of(k, a)]);
    endtask

    task automatic reg_load(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        int lat;
        bit wl;
        do_req(0, 1'b1, 1'b0, a, 32'h0, 4'h0, rd, lat, wl);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check(tag, rd, exp);
    endtask

    task automatic tx_store(input logic [31:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        bit wl;
        do_req(0, 1'b0, 1'b1, a, {24'hABCDEF, b}, s, rd, lat, wl);
        check("tx_store_latency", 32'(lat), 32'd2);
        check("tx_store_kind", {31'b0, wl}, 32'd0);
        if (a == TX_A && s[0]) txq.push_back(b);
    endtask

    function automatic logic [31:0] status_model();
        return {(txq.size() == 16), 15'b0, 16'(txq.size())};
    endfunction

    task automatic chk_reset(input int k);
        check($sformatf("rst_load_done%0d", k),  {31'b0, load_done[k]}, 32'd0);
        check($sformatf("rst_store_done%0d", k), {31'b0, store_done[k]}, 32'd0);
        check($sformatf("rst_data_l%0d", k),     data_l[k], 32'd0);
        check($sformatf("rst_tx_valid%0d", k),   {31'b0, tx_valid[k]}, 32'd0);
        check($sformatf("rst_tx_data%0d", k),    {24'b0, tx_data[k]}, 32'd0);
        check($sformatf("rst_proto_err%0d", k),  {31'b0, perr[k]}, 32'd0);
    endtask

    task automatic rand_phase(input int k);
        int widx [$];
        int idx;
        logic [31:0] rd;
        for (int i = 0; i < 12; i++) begin
            idx = int'($urandom_range(0, 16383));
            ram_store(k, mk_addr(idx), $urandom, 4'hF);
            widx.push_back(idx);
        end
        for (int i = 0; i < 30; i++) begin
            idx = widx[$urandom_range(0, widx.size() - 1)];
            if ($urandom_range(0, 1) == 0) ram_store(k, mk_addr(idx), $urandom, 4'($urandom_range(1, 15)));
            else ram_load(k, mk_addr(idx), rd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int          lat;
        bit          wl, seen;

        for (int k = 0; k < 2; k++) begin
            addr_i[k] = '0; wdat_i[k] = '0; sel_i[k] = '0;
            st_i[k] = 1'b0; ld_i[k] = 1'b0; rdy_i[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic RAM with no wait states, then a single-lane update.
        ram_store(0, 32'h40, 32'hDEADBEEF, 4'hF);
        ram_load(0, 32'h40, rd);
        check("basic_data", rd, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("load_data_hold", data_l[0], 32'hDEADBEEF);
        check("load_done_single", {31'b0, load_done[0]}, 32'd0);
        ram_store(0, 32'h40, 32'h000000AA, 4'b0001);
        ram_load(0, 32'h40, rd);
        check("byte_lane_data", rd, 32'hDEADBEAA);

        // Aliasing with three wait states.
        ram_store(1, 32'h0001_0040, 32'h12345678, 4'hF);
        ram_load(1, 32'h40, rd);
        check("alias_data", rd, 32'h12345678);

        // Back-to-back random traffic on both responders.
        rand_phase(0);
        rand_phase(1);

        // TX: first push shows no fall-through, then fill to full.
        b = 8'($urandom);
        st_i[0] = 1'b1; addr_i[0] = TX_A; wdat_i[0] = {24'h0, b}; sel_i[0] = 4'hF;
        @(posedge clk); #1;
        st_i[0] = 1'b0;
        check("tx_no_fallthrough", {31'b0, tx_valid[0]}, 32'd0);
        @(posedge clk); #1;
        check("tx_first_done", {31'b0, store_done[0]}, 32'd1);
        txq.push_back(b);
        check("tx_first_valid", {31'b0, tx_valid[0]}, 32'd1);
        check("tx_first_head", {24'b0, tx_data[0]}, {24'b0, txq[0]});
        for (int i = 0; i < 15; i++) tx_store(TX_A, 8'($urandom), 4'hF);
        reg_load(STAT_A, 32'h8000_0010, "status_full");
        tx_store(TX_A, 8'h77, 4'b1110);
        tx_store(STAT_A, 8'h33, 4'hF);
        reg_load(STAT_A, status_model(), "status_after_nopush");
        reg_load(TX_A, 32'h0, "tx_data_load");

        // Seventeenth push stalls until a single pop.
        b = 8'($urandom);
        st_i[0] = 1'b1; addr_i[0] = TX_A; wdat_i[0] = {24'h0, b}; sel_i[0] = 4'hF;
        @(posedge clk); #1;
        st_i[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (store_done[0]) seen = 1'b1;
        end
        check("tx_stall_no_done", {31'b0, seen}, 32'd0);
        rdy_i[0] = 1'b1;
        @(posedge clk); #1;
        rdy_i[0] = 1'b0;
        void'(txq.pop_front());
        lat = (store_done[0]) ? 1 : -1;
        for (int c = 2; c <= 10 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (store_done[0]) lat = c;
        end
        check("tx_stall_release", 32'(lat), 32'd2);
        txq.push_back(b);
        reg_load(STAT_A, status_model(), "status_refill");
        check("status_refill_const", status_model(), 32'h8000_0010);

        // Drain and compare every byte in order.
        rdy_i[0] = 1'b1;
        while (txq.size() > 0) begin
            check("drain_valid", {31'b0, tx_valid[0]}, 32'd1);
            check("drain_byte", {24'b0, tx_data[0]}, {24'b0, txq[0]});
            @(posedge clk); #1;
            void'(txq.pop_front());
        end
        rdy_i[0] = 1'b0;
        check("drain_empty_valid", {31'b0, tx_valid[0]}, 32'd0);
        check("drain_empty_data", {24'b0, tx_data[0]}, 32'd0);

        // Protocol error: load strobe during WAIT is dropped.
        check("perr1_clear", {31'b0, perr[1]}, 32'd0);
        st_i[1] = 1'b1; addr_i[1] = 32'hC0; wdat_i[1] = 32'hCAFEF00D; sel_i[1] = 4'hF;
        @(posedge clk); #1;
        st_i[1] = 1'b0;
        @(posedge clk); #1;
        ld_i[1] = 1'b1; addr_i[1] = 32'h200;
        @(posedge clk); #1;
        ld_i[1] = 1'b0;
        check("perr_wait_set", {31'b0, perr[1]}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("perr_orig_done", {31'b0, store_done[1]}, 32'd1);
        ram_m[key_of(1, 32'hC0)] = 32'hCAFEF00D;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (load_done[1] || store_done[1]) seen = 1'b1;
        end
        check("perr_dropped_no_done", {31'b0, seen}, 32'd0);
        ram_load(1, 32'hC0, rd);
        check("perr_sticky", {31'b0, perr[1]}, 32'd1);

        // Protocol error: simultaneous load and store behaves as a load.
        check("perr0_clear", {31'b0, perr[0]}, 32'd0);
        do_req(0, 1'b1, 1'b1, 32'h40, 32'h11111111, 4'hF, rd, lat, wl);
        check("both_latency", 32'(lat), 32'd2);
        check("both_kind", {31'b0, wl}, 32'd1);
        check("both_data", rd, ram_m[key_of(0, 32'h40)]);
        check("both_perr", {31'b0, perr[0]}, 32'd1);
        ram_load(0, 32'h40, rd);

        // Reset mid-operation: store in WAIT aborted, RAM kept.
        tx_store(TX_A, 8'h5A, 4'hF);
        ram_store(1, 32'h80, 32'h0BADF00D, 4'hF);
        ram_load(1, 32'h80, rd);
        st_i[1] = 1'b1; addr_i[1] = 32'h80; wdat_i[1] = 32'hFFFFFFFF; sel_i[1] = 4'hF;
        @(posedge clk); #1;
        st_i[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        txq.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (load_done[1] || store_done[1]) seen = 1'b1;
        end
        check("reset_no_done", {31'b0, seen}, 32'd0);
        ram_load(1, 32'h80, rd);
        check("reset_ram_kept", rd, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
